// File: rtl/alu_multiword_seq_pkg.sv
// Shared types for the multi-word ALU sequencer: ALU opcodes, flag
// indices, sequencer opcodes/states and the port-group bundles.
package alu_multiword_seq_pkg;

    typedef enum logic [3:0] {
        Alu_Add = 4'd0,
        Alu_Adc = 4'd1,
        Alu_Sub = 4'd2,
        Alu_Sbc = 4'd3,
        Alu_And = 4'd4,
        Alu_Or  = 4'd5,
        Alu_Xor = 4'd6
    } AluOper;

    // Flag vector layout is {N, V, Z, C}
    localparam int FlagC = 0;
    localparam int FlagZ = 1;
    localparam int FlagV = 2;
    localparam int FlagN = 3;

    typedef enum logic [2:0] {
        MwAdd = 3'd0,
        MwSub = 3'd1,
        MwAnd = 3'd2,
        MwOr  = 3'd3,
        MwXor = 3'd4
    } MwOp;

    typedef enum logic [1:0] {
        MwIdle = 2'd0,
        MwRun  = 2'd1,
        MwDone = 2'd2
    } MwState;

    localparam int MW_WORD_WIDTH = 32;
    localparam int MW_MAX_WORDS  = 4;
    localparam int MW_NW_WIDTH   = $clog2(MW_MAX_WORDS + 1);

    typedef struct packed {
        logic                                  start_valid;
        MwOp                                   op;
        logic [MW_NW_WIDTH-1:0]                num_words;
        logic [MW_MAX_WORDS*MW_WORD_WIDTH-1:0] a;
        logic [MW_MAX_WORDS*MW_WORD_WIDTH-1:0] b;
        logic [3:0]                            flags;
    } StrcInMwSeq;

    typedef struct packed {
        logic                                  start_ready;
        logic [MW_MAX_WORDS*MW_WORD_WIDTH-1:0] result;
        logic [3:0]                            flags;
        logic                                  done;
    } StrcOutMwSeq;

    function automatic logic is_arith(input MwOp op);
        return (op == MwAdd) || (op == MwSub);
    endfunction

endpackage

// File: rtl/alu_multiword_seq.sv
// Multi-word sequencer: drives the shared word ALU one word per cycle,
// LSW first, chaining carry/borrow through C.
// Ports: start_valid/start_ready request handshake with op, num_words,
//   a_in, b_in, flags_in; alu_oper/alu_a/alu_b/alu_flags drive the ALU,
//   alu_out/alu_flags_out return from it; result/flags_out/done report.
module alu_multiword_seq
    import alu_multiword_seq_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int MAX_WORDS  = 4,
    parameter int NW_WIDTH   = $clog2(MAX_WORDS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  MwOp                             op,
    input  logic [NW_WIDTH-1:0]             num_words,
    input  logic [MAX_WORDS*WORD_WIDTH-1:0] a_in,
    input  logic [MAX_WORDS*WORD_WIDTH-1:0] b_in,
    input  logic [3:0]                      flags_in,
    output AluOper                          alu_oper,
    output logic [WORD_WIDTH-1:0]           alu_a,
    output logic [WORD_WIDTH-1:0]           alu_b,
    output logic [3:0]                      alu_flags,
    input  logic [WORD_WIDTH-1:0]           alu_out,
    input  logic [3:0]                      alu_flags_out,
    output logic [MAX_WORDS*WORD_WIDTH-1:0] result,
    output logic [3:0]                      flags_out,
    output logic                            done
);

    localparam int IDX_WIDTH = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam logic [NW_WIDTH-1:0] MAX_NW = NW_WIDTH'(MAX_WORDS);
    localparam logic [NW_WIDTH-1:0] ONE_NW = NW_WIDTH'(1);

    MwState                state_q;
    MwState                state_d;
    MwOp                   op_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [IDX_WIDTH-1:0]  last_q;
    logic [IDX_WIDTH-1:0]  last_d;
    logic [NW_WIDTH-1:0]   nw_eff;
    logic [WORD_WIDTH-1:0] a_w   [MAX_WORDS];
    logic [WORD_WIDTH-1:0] b_w   [MAX_WORDS];
    logic [WORD_WIDTH-1:0] res_w [MAX_WORDS];
    logic [3:0]            wflags_q;
    logic                  run_z_q;
    logic [3:0]            flags_q;
    logic                  done_q;
    logic                  accept;
    logic                  last_word;
    logic                  arith;

    assign accept    = start_valid && (state_q == MwIdle);
    assign last_word = (idx_q == last_q);
    assign arith     = is_arith(op_q);

    // 0 words means 1; oversize requests clamp to the operand width
    always_comb begin
        nw_eff = num_words;
        if (num_words == '0) begin
            nw_eff = ONE_NW;
        end else if (num_words > MAX_NW) begin
            nw_eff = MAX_NW;
        end
        last_d = IDX_WIDTH'(nw_eff - ONE_NW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MwIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        alu_oper    = Alu_Add;
        alu_a       = '0;
        alu_b       = '0;
        alu_flags   = '0;
        unique case (state_q)
            MwIdle: begin
                start_ready = 1'b1;
                if (accept) begin
                    state_d = MwRun;
                end
            end
            MwRun: begin
                alu_a     = a_w[idx_q];
                alu_b     = b_w[idx_q];
                alu_flags = wflags_q;
                unique case (1'b1)
                    op_q == MwAdd:
                        alu_oper = (idx_q == '0) ? Alu_Add : Alu_Adc;
                    op_q == MwSub:
                        alu_oper = (idx_q == '0) ? Alu_Sub : Alu_Sbc;
                    op_q == MwAnd: alu_oper = Alu_And;
                    op_q == MwOr:  alu_oper = Alu_Or;
                    op_q == MwXor: alu_oper = Alu_Xor;
                    default:       alu_oper = Alu_Add;
                endcase
                if (last_word) begin
                    state_d = MwDone;
                end
            end
            MwDone: begin
                state_d = MwIdle;
            end
            default: begin
                state_d = MwIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= MwAdd;
            idx_q    <= '0;
            last_q   <= '0;
            wflags_q <= '0;
            run_z_q  <= 1'b0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                a_w[i]   <= '0;
                b_w[i]   <= '0;
                res_w[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                op_q     <= op;
                idx_q    <= '0;
                last_q   <= last_d;
                wflags_q <= flags_in;
                run_z_q  <= 1'b1;
                for (int i = 0; i < MAX_WORDS; i++) begin
                    a_w[i]   <= a_in[i*WORD_WIDTH +: WORD_WIDTH];
                    b_w[i]   <= b_in[i*WORD_WIDTH +: WORD_WIDTH];
                    res_w[i] <= '0;
                end
            end
            if (state_q == MwRun) begin
                res_w[idx_q] <= alu_out;
                run_z_q      <= run_z_q & alu_flags_out[FlagZ];
                if (arith) begin
                    wflags_q[FlagC] <= alu_flags_out[FlagC];
                end
                if (last_word) begin
                    flags_q[FlagN] <= alu_flags_out[FlagN];
                    flags_q[FlagV] <= arith ? alu_flags_out[FlagV]
                                            : wflags_q[FlagV];
                    flags_q[FlagZ] <= run_z_q & alu_flags_out[FlagZ];
                    flags_q[FlagC] <= arith ? alu_flags_out[FlagC]
                                            : wflags_q[FlagC];
                    done_q         <= 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < MAX_WORDS; g++) begin : g_res
        assign result[g*WORD_WIDTH +: WORD_WIDTH] = res_w[g];
    end

    assign flags_out = flags_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq with a behavioural word ALU
// attached to its ALU ports.
module tb_alu_multiword_seq;
    import alu_multiword_seq_pkg::*;

    localparam int W   = 32;
    localparam int MW  = 4;
    localparam int NWW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_valid = 1'b0;
    logic              start_ready;
    MwOp               op = MwAdd;
    logic [NWW-1:0]    num_words = '0;
    logic [MW*W-1:0]   a_in = '0;
    logic [MW*W-1:0]   b_in = '0;
    logic [3:0]        flags_in = '0;
    AluOper            alu_oper;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [3:0]        alu_flags;
    logic [W-1:0]      alu_out;
    logic [3:0]        alu_flags_out;
    logic [MW*W-1:0]   result;
    logic [3:0]        flags_out;
    logic              done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    alu_multiword_seq #(
        .WORD_WIDTH(W),
        .MAX_WORDS (MW),
        .NW_WIDTH  (NWW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .num_words    (num_words),
        .a_in         (a_in),
        .b_in         (b_in),
        .flags_in     (flags_in),
        .alu_oper     (alu_oper),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_flags    (alu_flags),
        .alu_out      (alu_out),
        .alu_flags_out(alu_flags_out),
        .result       (result),
        .flags_out    (flags_out),
        .done         (done)
    );

    // Reference word ALU
    logic [W:0] sum;
    logic       v;
    logic       c;
    always_comb begin
        sum = '0;
        v   = alu_flags[FlagV];
        c   = alu_flags[FlagC];
        case (alu_oper)
            Alu_Add: sum = {1'b0, alu_a} + {1'b0, alu_b};
            Alu_Adc: sum = {1'b0, alu_a} + {1'b0, alu_b}
                         + {{W{1'b0}}, alu_flags[FlagC]};
            Alu_Sub: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 1'b1;
            Alu_Sbc: sum = {1'b0, alu_a} + {1'b0, ~alu_b}
                         + {{W{1'b0}}, alu_flags[FlagC]};
            Alu_And: sum = {1'b0, alu_a & alu_b};
            Alu_Or:  sum = {1'b0, alu_a | alu_b};
            Alu_Xor: sum = {1'b0, alu_a ^ alu_b};
            default: sum = '0;
        endcase
        if (alu_oper == Alu_Add || alu_oper == Alu_Adc) begin
            c = sum[W];
            v = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end else if (alu_oper == Alu_Sub || alu_oper == Alu_Sbc) begin
            c = sum[W];
            v = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end
        alu_out       = sum[W-1:0];
        alu_flags_out = {sum[W-1], v, (sum[W-1:0] == '0), c};
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // lat counts the accept cycle as 1; pulse_ok is set when done drops
    // again one cycle after it was seen; dalu is alu_a in the done cycle.
    task automatic run_op(input MwOp o, input logic [NWW-1:0] nw,
                          input logic [MW*W-1:0] a, input logic [MW*W-1:0] b,
                          input logic [3:0] fl, output int lat,
                          output logic pulse_ok, output logic [W-1:0] dalu);
        logic seen;
        @(negedge clk);
        op = o;
        num_words = nw;
        a_in = a;
        b_in = b;
        flags_in = fl;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        pulse_ok = 1'b0;
        dalu = '1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                dalu = alu_a;
                break;
            end
            @(posedge clk);
            #1 lat++;
        end
        if (seen) begin
            @(posedge clk);
            #1 pulse_ok = !done;
        end else begin
            lat = -1;
        end
    endtask

    int         lat;
    logic       pok;
    logic [W-1:0] dalu;
    logic       seen_done;

    initial begin
        // Reset state
        #12;
        chk("rst_result", 128'(result), 128'h0);
        chk("rst_flags", 128'(flags_out), 128'h0);
        chk("rst_done", 128'(done), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 128'(start_ready), 128'h1);
        chk("idle_oper", 128'(alu_oper), 128'(Alu_Add));
        chk("idle_alu_a", 128'(alu_a), 128'h0);

        // Add with carry across words
        run_op(MwAdd, 3'd2, 128'h00000000_FFFFFFFF, 128'h1, 4'h0,
               lat, pok, dalu);
        chk("add2_lat", 128'(lat), 128'd3);
        chk("add2_pulse", 128'(pok), 128'h1);
        chk("add2_res", result, 128'h00000001_00000000);
        chk("add2_flags", 128'(flags_out), 128'h0);

        // Sub with borrow propagating through
        run_op(MwSub, 3'd2, 128'h0, 128'h1, 4'h0, lat, pok, dalu);
        chk("sub2_lat", 128'(lat), 128'd3);
        chk("sub2_res", result, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
        chk("sub2_flags", 128'(flags_out), 128'h8);

        // Full-width add overflowing into sign bit
        run_op(MwAdd, 3'd4, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
               128'h1, 4'h0, lat, pok, dalu);
        chk("add4_lat", 128'(lat), 128'd5);
        chk("add4_res", result, 128'h80000000_00000000_00000000_00000000);
        chk("add4_flags", 128'(flags_out), 128'hC);

        // Xor over 3 words; word 3 differs and must be skipped
        run_op(MwXor, 3'd3, 128'hDEAD0000_12345678_9ABCDEF0_0F0F0F0F,
               128'h00000000_12345678_9ABCDEF0_0F0F0F0F, 4'b0101,
               lat, pok, dalu);
        chk("xor3_lat", 128'(lat), 128'd4);
        chk("xor3_res", result, 128'h0);
        chk("xor3_flags", 128'(flags_out), 128'h7);
        chk("done_alu_a", 128'(dalu), 128'h0);

        // Single-word and, C passes through, incoming Z ignored
        run_op(MwAnd, 3'd1, 128'hF0F0F0F0, 128'hFF00FF00, 4'b0011,
               lat, pok, dalu);
        chk("and1_res", result, 128'hF000F000);
        chk("and1_flags", 128'(flags_out), 128'h9);

        // Two-word or producing zero
        run_op(MwOr, 3'd2, 128'h0, 128'h0, 4'h0, lat, pok, dalu);
        chk("or2_res", result, 128'h0);
        chk("or2_flags", 128'(flags_out), 128'h2);

        // num_words = 0 behaves as one word
        run_op(MwAdd, 3'd0, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_00000005,
               128'h11111111_22222222_33333333_00000007, 4'h0,
               lat, pok, dalu);
        chk("n0_lat", 128'(lat), 128'd2);
        chk("n0_res", result, 128'hC);

        // num_words = 7 clamps to 4
        run_op(MwAdd, 3'd7, 128'h00000001_00000001_00000001_00000001,
               128'h00000002_00000002_00000002_00000002, 4'h0,
               lat, pok, dalu);
        chk("n7_lat", 128'(lat), 128'd5);
        chk("n7_res", result, 128'h00000003_00000003_00000003_00000003);

        // A second request while busy is ignored
        @(negedge clk);
        op = MwAdd;
        num_words = 3'd4;
        a_in = 128'h00000001_00000001_00000001_00000001;
        b_in = 128'h00000002_00000002_00000002_00000002;
        flags_in = 4'h0;
        start_valid = 1'b1;
        @(posedge clk);
        #1;
        op = MwXor;
        a_in = 128'h55555555_55555555_55555555_55555555;
        b_in = 128'h12345678_12345678_12345678_12345678;
        chk("busy_ready", 128'(start_ready), 128'h0);
        @(posedge clk);
        #1 start_valid = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("busy_done", 128'(seen_done), 128'h1);
        chk("busy_res", result, 128'h00000003_00000003_00000003_00000003);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_res", result, 128'h00000003_00000003_00000003_00000003);
        chk("hold_ready", 128'(start_ready), 128'h1);

        // Reset mid-run: partial result and old flags are cleared
        run_op(MwXor, 3'd1, 128'h0, 128'h0, 4'b0101, lat, pok, dalu);
        chk("pre_flags", 128'(flags_out), 128'h7);
        @(negedge clk);
        op = MwAdd;
        num_words = 3'd4;
        a_in = 128'h00000001_00000001_00000001_00000001;
        b_in = 128'h00000002_00000002_00000002_00000002;
        flags_in = 4'h0;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_partial", result, 128'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_res", result, 128'h0);
        chk("mid_rst_flags", 128'(flags_out), 128'h0);
        chk("mid_rst_done", 128'(done), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", 128'(start_ready), 128'h1);
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1 seen_done = seen_done | done;
        end
        chk("mid_rst_nodone", 128'(seen_done), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
